cdc_req_receiver: RTL and testbench

CDC_REQ_RECEIVER -- requirements
Module: cdc_req_receiver

---
 rtl/cdc_req_receiver.sv | 137 +++++++++++++
 tb/tb_cdc_req_receiver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_req_receiver.sv
// ---------------------------------------------------------------------------
// cdc_req_receiver
//
// Fast-domain end of a toggle-handshake clock-domain crossing. A sender in
// the divided-clock domain holds data_i stable and flips req_tgl_i once per
// word. This block:
//   1. synchronizes req_tgl_i through SYNC_STAGES flops,
//   2. turns each toggle into a single-cycle edge event,
//   3. captures data_i into out_data and presents it with out_valid,
//   4. flips ack_tgl_o when the fast-domain consumer takes the word.
//
// Ports
//   clk_hf      in   undivided fast clock, rising edge only
//   reset       in   asynchronous, active-high reset
//   req_tgl_i   in   request toggle from the divided-clock domain
//   data_i      in   DATA_W word, stable while a request is outstanding
//   ack_tgl_o   out  acknowledge toggle back to the sender (registered)
//   out_valid   out  out_data holds an unconsumed word
//   out_data    out  captured word (registered)
//   out_ready   in   consumer accepts the word this cycle
//   overrun     out  sticky: a request arrived while a word was pending
//   xfer_count  out  completed transfers, wraps at 2^16
//
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module cdc_req_receiver #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_hf,
    input  logic              reset,
    input  logic              req_tgl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_tgl_o,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              overrun,
    output logic [15:0]       xfer_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // ---------------------------------------------------------------
    // Request synchronizer and edge detector
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_evt;

    // prev_q follows the last sync stage every cycle, so a toggle is seen
    // as a difference for exactly one cycle.
    always_ff @(posedge clk_hf or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_evt = sync_q[SYNC_STAGES-1] ^ prev_q;

    // ---------------------------------------------------------------
    // Capture / hold FSM
    // ---------------------------------------------------------------
    logic [0:0]        state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              ack_q,   ack_d;
    logic              ovr_q,   ovr_d;
    logic [15:0]       cnt_q,   cnt_d;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        ack_d   = ack_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // data_i is already stable: the sender set it before the
                // toggle, and the toggle needed SYNC_STAGES cycles to get here.
                if (edge_evt) begin
                    data_d  = data_i;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A new request while holding is dropped and flagged; it does
                // not block an acceptance in the same cycle.
                if (edge_evt) begin
                    ovr_d = 1'b1;
                end
                if (out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_hf or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack_tgl_o  = ack_q;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign overrun    = ovr_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_cdc_req_receiver.sv
// ---------------------------------------------------------------------------
// tb_cdc_req_receiver
//
// Directed bench for cdc_req_receiver. The stimulus process plays the
// divided-clock sender and pushes every word it expects to be delivered into
// a queue; a monitor pops and compares on each accepted output word. The
// stimulus process also checks latency, hold, overrun and reset behaviour
// directly against hand-derived values.
// ---------------------------------------------------------------------------
module tb_cdc_req_receiver;

    logic        clk_hf = 1'b0;
    logic        reset;
    logic        req_tgl_i;
    logic [31:0] data_i;
    logic        ack_tgl_o;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        overrun;
    logic [15:0] xfer_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        ack_exp;

    cdc_req_receiver #(.DATA_W(32), .SYNC_STAGES(2)) dut (
        .clk_hf     (clk_hf),
        .reset      (reset),
        .req_tgl_i  (req_tgl_i),
        .data_i     (data_i),
        .ack_tgl_o  (ack_tgl_o),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .xfer_count (xfer_count)
    );

    always #5 clk_hf = ~clk_hf;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_hf);
    endtask

    // Sender: new word, flip the request, expect it at the output.
    task automatic send(input logic [31:0] w);
        data_i    = w;
        req_tgl_i = ~req_tgl_i;
        exp_q.push_back(w);
    endtask

    task automatic wait_ack(input logic tgt, input string nm);
        int k = 0;
        while (ack_tgl_o !== tgt && k < 16) begin
            tick();
            k++;
        end
        check(nm, ack_tgl_o, tgt);
    endtask

    // Scoreboard monitor: sample 1 time unit before each rising edge.
    initial begin
        logic [31:0] w;
        forever begin
            @(negedge clk_hf);
            #4;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got 0x%0h, required no word", out_data);
                end else begin
                    w = exp_q.pop_front();
                    check("sb_data", out_data, w);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_tgl_i = 1'b0;
        data_i    = 32'h0;
        out_ready = 1'b0;
        ack_exp   = 1'b0;

        // Reset state, before any clock edge
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data",  out_data, 0);
        check("rst_ack",   ack_tgl_o, 0);
        check("rst_ovr",   overrun, 0);
        check("rst_cnt",   xfer_count, 0);
        tick(); tick();
        reset = 1'b0;

        // Basic transfer and latency
        out_ready = 1'b1;
        send(32'hDEADBEEF);
        tick(); check("lat_e1_valid", out_valid, 0);
        tick(); check("lat_e2_valid", out_valid, 0);
        tick(); check("lat_e3_valid", out_valid, 1);
                check("lat_e3_data",  out_data, 32'hDEADBEEF);
        tick(); check("basic_valid_clr", out_valid, 0);
                check("basic_ack", ack_tgl_o, 1);
                check("basic_cnt", xfer_count, 1);
        out_ready = 1'b0;
        tick(); check("idle_ready_noeffect", xfer_count, 1);

        // Backpressure
        send(32'h12345678);
        repeat (3) tick();
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data",  out_data, 32'h12345678);
            check("bp_hold_ack",   ack_tgl_o, 1);
            check("bp_hold_cnt",   xfer_count, 1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_valid_clr", out_valid, 0);
        check("bp_ack", ack_tgl_o, 0);
        check("bp_cnt", xfer_count, 2);

        // Overrun: second request while the first is still held
        out_ready = 1'b0;
        send(32'hAAAA0001);
        repeat (3) tick();
        check("ovr_valid", out_valid, 1);
        check("ovr_pre", overrun, 0);
        data_i    = 32'hBBBB0002;
        req_tgl_i = ~req_tgl_i;
        repeat (3) tick();
        check("ovr_flag", overrun, 1);
        check("ovr_data_kept", out_data, 32'hAAAA0001);
        out_ready = 1'b1;
        tick();
        check("ovr_valid_clr", out_valid, 0);
        check("ovr_ack", ack_tgl_o, 1);
        check("ovr_cnt", xfer_count, 3);
        repeat (6) tick();
        check("ovr_one_ack", ack_tgl_o, 1);
        check("ovr_no_recapture", out_valid, 0);
        check("ovr_cnt_stable", xfer_count, 3);
        check("ovr_data_stable", out_data, 32'hAAAA0001);
        check("ovr_sticky", overrun, 1);

        // Reset mid-operation, request left high across reset
        out_ready = 1'b0;
        send(32'h5555AAAA);
        repeat (3) tick();
        check("mid_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data",  out_data, 0);
        check("mid_rst_ack",   ack_tgl_o, 0);
        check("mid_rst_cnt",   xfer_count, 0);
        check("mid_rst_ovr",   overrun, 0);
        exp_q.delete();
        tick(); tick();
        check("mid_req_high", req_tgl_i, 1);
        data_i = 32'h0BADF00D;
        exp_q.push_back(32'h0BADF00D);
        out_ready = 1'b1;
        reset = 1'b0;
        repeat (2) tick();
        check("mid_post_e2", out_valid, 0);
        tick();
        check("mid_post_valid", out_valid, 1);
        check("mid_post_data", out_data, 32'h0BADF00D);
        tick();
        check("mid_post_ack", ack_tgl_o, 1);
        repeat (10) tick();
        check("mid_one_capture", xfer_count, 1);
        check("mid_idle", out_valid, 0);

        // Back-to-back 8 transfers; slow clock modelled as 4 fast cycles
        reset = 1'b1;
        req_tgl_i = 1'b0;
        exp_q.delete();
        tick(); tick();
        reset = 1'b0;
        ack_exp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) repeat (4) tick();
            send(32'hC0DE0000 + 32'(i) * 32'h01010101);
            ack_exp = ~ack_exp;
            wait_ack(ack_exp, "b2b_ack");
        end
        tick();
        check("b2b_cnt", xfer_count, 8);
        check("b2b_ovr", overrun, 0);
        check("b2b_all_delivered", exp_q.size(), 0);

        // Counter wrap over 65536 full handshakes
        reset = 1'b1;
        req_tgl_i = 1'b0;
        exp_q.delete();
        tick(); tick();
        reset = 1'b0;
        ack_exp = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            if (i == 65535) check("wrap_ffff", xfer_count, 16'hFFFF);
            send(32'(i));
            ack_exp = ~ack_exp;
            wait_ack(ack_exp, "wrap_ack");
        end
        tick();
        check("wrap_cnt", xfer_count, 0);
        check("wrap_ovr", overrun, 0);
        check("wrap_ack_final", ack_tgl_o, 0);
        check("wrap_all_delivered", exp_q.size(), 0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
